// File: rtl/axis_uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between several AXI-Stream producers.
// Each grant moves one word into a holding register and waits for tx_done (or a watchdog abort) before the next grant.
module axis_uart_tx_arbiter #(
    parameter int NUM_SRC        = 4,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [NUM_SRC-1:0]                s_tvalid,
    input  logic [NUM_SRC*AXI_DATA_WIDTH-1:0] s_tdata,
    output logic [NUM_SRC-1:0]                s_tready,
    output logic                              m_tvalid,
    output logic [AXI_DATA_WIDTH-1:0]         m_tdata,
    input  logic                              m_tready,
    input  logic                              tx_done,
    output logic [$clog2(NUM_SRC)-1:0]        grant_id,
    output logic                              busy,
    output logic                              timeout_err
);

    localparam int IDW   = $clog2(NUM_SRC);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic             WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDW-1:0]   LAST_RST = IDW'(NUM_SRC - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [IDW-1:0]            last_grant_q, last_grant_d;
    logic [IDW-1:0]            grant_id_q, grant_id_d;
    logic [NUM_SRC-1:0]        s_tready_q, s_tready_d;
    logic                      m_tvalid_q, m_tvalid_d;
    logic [AXI_DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic                      busy_q, busy_d;
    logic                      timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]          wd_cnt_q, wd_cnt_d;

    logic                      any_vld;
    logic [IDW-1:0]            sel;
    logic [NUM_SRC-1:0]        sel_oh;
    logic [AXI_DATA_WIDTH-1:0] sel_data;

    // First requester strictly after 'last', wrapping modulo NUM_SRC; 'last' itself is checked last.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                               input logic [IDW-1:0]     last);
        logic [IDW-1:0] pick;
        logic [IDW-1:0] idx;
        logic           found;
        int             sum;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            sum = int'(last) + k;
            if (sum >= NUM_SRC) begin
                sum = sum - NUM_SRC;
            end
            idx = IDW'(sum);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return pick;
    endfunction

    assign any_vld = |s_tvalid;
    assign sel     = rr_pick(s_tvalid, last_grant_q);

    always_comb begin
        sel_oh   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == IDW'(i)) begin
                sel_oh[i] = 1'b1;
                sel_data  = s_tdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_id_d    = grant_id_q;
        s_tready_d    = '0;
        m_tvalid_d    = m_tvalid_q;
        m_tdata_d     = m_tdata_q;
        busy_d        = busy_q;
        timeout_err_d = 1'b0;
        wd_cnt_d      = wd_cnt_q;

        case (state_q)
            ST_IDLE: begin
                busy_d     = 1'b0;
                m_tvalid_d = 1'b0;
                if (any_vld) begin
                    grant_id_d = sel;
                    s_tready_d = sel_oh;
                    m_tdata_d  = sel_data;
                    m_tvalid_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_SEND;
                end
            end

            ST_SEND: begin
                if (m_tready) begin
                    m_tvalid_d = 1'b0;
                    wd_cnt_d   = '0;
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (wd_cnt_q != CNT_MAX) begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
                // tx_done takes precedence over a watchdog expiry in the same cycle.
                if (tx_done) begin
                    last_grant_d = grant_id_q;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end else if (WD_EN && (wd_cnt_q == CNT_LAST)) begin
                    timeout_err_d = 1'b1;
                    last_grant_d  = grant_id_q;
                    busy_d        = 1'b0;
                    state_d       = ST_IDLE;
                end
            end

            default: begin
                busy_d     = 1'b0;
                m_tvalid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= LAST_RST;
            grant_id_q    <= '0;
            s_tready_q    <= '0;
            m_tvalid_q    <= 1'b0;
            m_tdata_q     <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            wd_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            s_tready_q    <= s_tready_d;
            m_tvalid_q    <= m_tvalid_d;
            m_tdata_q     <= m_tdata_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            wd_cnt_q      <= wd_cnt_d;
        end
    end

    assign s_tready    = s_tready_q;
    assign m_tvalid    = m_tvalid_q;
    assign m_tdata     = m_tdata_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Bench for axis_uart_tx_arbiter: per-cycle vector table for reset, single grant and round-robin,
// followed by hand sequences for back-pressure, watchdog, done/timeout collision and mid-word reset.
module tb_axis_uart_tx_arbiter;

    localparam int NS = 4;
    localparam int W  = 32;
    localparam int TO = 16;

    logic          aclk;
    logic          aresetn;
    logic [NS-1:0] s_tvalid;
    logic [NS*W-1:0] s_tdata;
    logic [NS-1:0] s_tready;
    logic          m_tvalid;
    logic [W-1:0]  m_tdata;
    logic          m_tready;
    logic          tx_done;
    logic [1:0]    grant_id;
    logic          busy;
    logic          timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    axis_uart_tx_arbiter #(
        .NUM_SRC(NS),
        .AXI_DATA_WIDTH(W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_tvalid(s_tvalid),
        .s_tdata(s_tdata),
        .s_tready(s_tready),
        .m_tvalid(m_tvalid),
        .m_tdata(m_tdata),
        .m_tready(m_tready),
        .tx_done(tx_done),
        .grant_id(grant_id),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic        rstn;
        logic [3:0]  vld;
        logic        mrdy;
        logic        done;
        logic [3:0]  str;
        logic        mv;
        logic        bsy;
        logic [1:0]  gid;
        logic        te;
        logic        chk_dg;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] src_word(input int i);
        return 32'hA5A5_0100 | 32'(i);
    endfunction

    function automatic vec_t mk(input logic rstn, input logic [3:0] vld, input logic mrdy,
                                input logic done, input logic [3:0] str, input logic mv,
                                input logic bsy, input logic [1:0] gid, input logic te,
                                input logic chk_dg, input logic [31:0] data);
        vec_t v;
        v.rstn = rstn; v.vld = vld; v.mrdy = mrdy; v.done = done;
        v.str = str; v.mv = mv; v.bsy = bsy; v.gid = gid; v.te = te;
        v.chk_dg = chk_dg; v.data = data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rstn, input logic [3:0] vld, input logic mrdy, input logic done);
        aresetn  = rstn;
        s_tvalid = vld;
        m_tready = mrdy;
        tx_done  = done;
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic [3:0] str, input logic mv,
                           input logic bsy, input logic te);
        chk({tag, ".s_tready"}, 32'(s_tready), 32'(str));
        chk({tag, ".m_tvalid"}, 32'(m_tvalid), 32'(mv));
        chk({tag, ".busy"}, 32'(busy), 32'(bsy));
        chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(te));
    endtask

    task automatic chk_grant(input string tag, input int g);
        chk({tag, ".grant_id"}, 32'(grant_id), 32'(g));
        chk({tag, ".m_tdata"}, m_tdata, src_word(g));
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            s_tdata[i*W +: W] = src_word(i);
        end
        aresetn  = 1'b0;
        s_tvalid = '0;
        m_tready = 1'b0;
        tx_done  = 1'b0;

        // Reset state
        vecs.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0, 0, 1, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0, 0, 1, 32'h0));
        // Only src2 valid; it drops tvalid after grant, word still proceeds
        vecs.push_back(mk(1, 4'b0100, 0, 0, 4'b0100, 1, 1, 2'd2, 0, 1, 32'hA5A5_0102));
        vecs.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 0, 1, 2'd2, 0, 1, 32'hA5A5_0102));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 0, 1, 2'd2, 0, 1, 32'hA5A5_0102));
        vecs.push_back(mk(1, 4'b0000, 0, 1, 4'b0000, 0, 0, 2'd2, 0, 0, 32'h0));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd2, 0, 0, 32'h0));
        // Reset again so source 0 has first priority
        vecs.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0, 0, 1, 32'h0));
        // All four valid for 8 words: grant, handshake, done per word
        for (int w = 0; w < 8; w++) begin
            vecs.push_back(mk(1, 4'b1111, 0, 0, 4'(1 << (w % 4)), 1, 1, 2'(w % 4), 0, 1, src_word(w % 4)));
            vecs.push_back(mk(1, 4'b1111, 1, 0, 4'b0000, 0, 1, 2'(w % 4), 0, 1, src_word(w % 4)));
            vecs.push_back(mk(1, 4'b1111, 0, 1, 4'b0000, 0, 0, 2'(w % 4), 0, 0, 32'h0));
        end

        for (int n = 0; n < vecs.size(); n++) begin
            string tag;
            tag = $sformatf("vec%0d", n);
            step(vecs[n].rstn, vecs[n].vld, vecs[n].mrdy, vecs[n].done);
            chk_ctl(tag, vecs[n].str, vecs[n].mv, vecs[n].bsy, vecs[n].te);
            if (vecs[n].chk_dg) begin
                chk({tag, ".grant_id"}, 32'(grant_id), 32'(vecs[n].gid));
                chk({tag, ".m_tdata"}, m_tdata, vecs[n].data);
            end
        end

        // Back-pressure: m_tready held low 5 cycles; a stray tx_done in SEND is ignored
        step(1, 4'b0001, 0, 0);
        chk_ctl("bp.grant", 4'b0001, 1, 1, 0);
        chk_grant("bp.grant", 0);
        for (int k = 1; k <= 5; k++) begin
            step(1, 4'b0000, 0, (k == 3));
            chk_ctl($sformatf("bp.hold%0d", k), 4'b0000, 1, 1, 0);
            chk_grant($sformatf("bp.hold%0d", k), 0);
        end
        step(1, 4'b0000, 1, 0);
        chk_ctl("bp.hs", 4'b0000, 0, 1, 0);
        step(1, 4'b0000, 0, 1);
        chk_ctl("bp.done", 4'b0000, 0, 0, 0);

        // Watchdog: src1 granted, tx_done never comes, src2 granted after the abort
        step(1, 4'b0110, 0, 0);
        chk_ctl("to.grant", 4'b0010, 1, 1, 0);
        chk_grant("to.grant", 1);
        step(1, 4'b0110, 1, 0);
        chk_ctl("to.hs", 4'b0000, 0, 1, 0);
        for (int k = 1; k < TO; k++) begin
            step(1, 4'b0110, 0, 0);
            chk_ctl($sformatf("to.wait%0d", k), 4'b0000, 0, 1, 0);
        end
        step(1, 4'b0110, 0, 0);
        chk_ctl("to.fire", 4'b0000, 0, 0, 1);
        step(1, 4'b0110, 0, 0);
        chk_ctl("to.next", 4'b0100, 1, 1, 0);
        chk_grant("to.next", 2);
        step(1, 4'b0000, 1, 0);
        step(1, 4'b0000, 0, 1);
        chk_ctl("to.done", 4'b0000, 0, 0, 0);

        // tx_done on the exact watchdog cycle: normal completion, no error pulse
        step(1, 4'b1000, 0, 0);
        chk_grant("tie.grant", 3);
        step(1, 4'b0000, 1, 0);
        for (int k = 1; k < TO; k++) begin
            step(1, 4'b0000, 0, 0);
        end
        chk_ctl("tie.pre", 4'b0000, 0, 1, 0);
        step(1, 4'b0000, 0, 1);
        chk_ctl("tie.edge", 4'b0000, 0, 0, 0);
        step(1, 4'b0000, 0, 0);
        chk_ctl("tie.after", 4'b0000, 0, 0, 0);

        // Reset during WAIT_DONE: src0 completes, src1 in flight, reset, then src0 wins again
        step(1, 4'b0001, 0, 0);
        chk_grant("rst.w0", 0);
        step(1, 4'b0000, 1, 0);
        step(1, 4'b0000, 0, 1);
        step(1, 4'b0010, 0, 0);
        chk_grant("rst.w1", 1);
        step(1, 4'b0000, 1, 0);
        step(1, 4'b0000, 0, 0);
        chk_ctl("rst.inwait", 4'b0000, 0, 1, 0);
        step(0, 4'b0011, 0, 0);
        chk_ctl("rst.asserted", 4'b0000, 0, 0, 0);
        chk("rst.grant_id", 32'(grant_id), 32'd0);
        chk("rst.m_tdata", m_tdata, 32'h0);
        step(1, 4'b0011, 0, 0);
        chk_ctl("rst.first", 4'b0001, 1, 1, 0);
        chk_grant("rst.first", 0);
        step(1, 4'b0000, 1, 0);
        step(1, 4'b0000, 0, 1);
        chk_ctl("rst.done", 4'b0000, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
